// File: rtl/lap_tracker.sv
// lap_tracker: per-player lap counting from world positions, finishing order,
// post-finish grace timer and the game-end level for the state encoder.
module lap_tracker #(
  parameter int unsigned LAPS         = 3,
  parameter logic [9:0]  FIN_X0       = 10'd0,
  parameter logic [9:0]  FIN_X1       = 10'd40,
  parameter logic [9:0]  FIN_Y0       = 10'd115,
  parameter logic [9:0]  FIN_Y1       = 10'd120,
  parameter logic [9:0]  CP_X0        = 10'd280,
  parameter logic [9:0]  CP_X1        = 10'd319,
  parameter logic [9:0]  CP_Y0        = 10'd100,
  parameter logic [9:0]  CP_Y1        = 10'd140,
  parameter int unsigned GRACE_CYCLES = 1000000000,
  parameter int unsigned GW           = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic [9:0] p1_x,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_x,
  input  logic [9:0] p2_y,
  output logic [1:0] p1_lap,
  output logic [1:0] p2_lap,
  output logic       p1_lap_pulse,
  output logic       p2_lap_pulse,
  output logic [1:0] p1_rank,
  output logic [1:0] p2_rank,
  output logic       is_game_end
);

  typedef enum logic [2:0] {
    GS_IDLE      = 3'd0,
    GS_SETTING   = 3'd1,
    GS_COUNTDOWN = 3'd3,
    GS_RACING    = 3'd4,
    GS_PAUSE     = 3'd5,
    GS_FINISH    = 3'd6
  } game_state_e;

  typedef enum logic [1:0] {
    NEED_CP  = 2'd0,
    NEED_FIN = 2'd1,
    DONE     = 2'd2
  } pstate_e;

  localparam logic [1:0]    LAPS_L     = 2'(LAPS);
  localparam logic [GW-1:0] GRACE_LAST = GW'(GRACE_CYCLES - 1);

  function automatic logic in_rect(input logic [9:0] x, input logic [9:0] y,
                                   input logic [9:0] x0, input logic [9:0] x1,
                                   input logic [9:0] y0, input logic [9:0] y1);
    return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  endfunction

  logic          racing;
  logic          clear;
  logic [1:0]    in_fin, in_cp;
  logic [1:0]    fin_entry, cp_entry;
  logic [1:0]    done_now;
  logic          grace_run;

  pstate_e       pst_q [2];
  pstate_e       pst_d [2];
  logic [1:0]    lap_q [2];
  logic [1:0]    lap_d [2];
  logic [1:0]    rank_q [2];
  logic [1:0]    rank_d [2];
  logic [1:0]    pulse_q, pulse_d;
  logic [1:0]    prev_fin_q, prev_fin_d;
  logic [1:0]    prev_cp_q, prev_cp_d;
  logic [GW-1:0] cnt_q, cnt_d;
  logic          end_q, end_d;

  // Region flags and entry edges against the registered region history
  always_comb begin
    in_fin[0]  = in_rect(p1_x, p1_y, FIN_X0, FIN_X1, FIN_Y0, FIN_Y1);
    in_fin[1]  = in_rect(p2_x, p2_y, FIN_X0, FIN_X1, FIN_Y0, FIN_Y1);
    in_cp[0]   = in_rect(p1_x, p1_y, CP_X0, CP_X1, CP_Y0, CP_Y1);
    in_cp[1]   = in_rect(p2_x, p2_y, CP_X0, CP_X1, CP_Y0, CP_Y1);
    fin_entry  = in_fin & ~prev_fin_q;
    cp_entry   = in_cp & ~prev_cp_q;
  end

  // Player FSMs, lap counting, ranking, grace timer and game-end
  always_comb begin
    racing     = (state == GS_RACING);
    clear      = (state == GS_IDLE) || (state == GS_SETTING);
    prev_fin_d = in_fin;
    prev_cp_d  = in_cp;
    pulse_d    = '0;
    done_now   = '0;
    cnt_d      = cnt_q;
    end_d      = end_q | ((rank_q[0] != 2'd0) && (rank_q[1] != 2'd0));
    for (int unsigned i = 0; i < 2; i++) begin
      pst_d[i]  = pst_q[i];
      lap_d[i]  = lap_q[i];
      rank_d[i] = rank_q[i];
    end

    // Checkpoint is tested before finish so one cycle yields one transition
    if (racing) begin
      for (int unsigned i = 0; i < 2; i++) begin
        case (pst_q[i])
          NEED_CP: begin
            if (cp_entry[i]) pst_d[i] = NEED_FIN;
          end
          NEED_FIN: begin
            if (fin_entry[i]) begin
              lap_d[i]   = lap_q[i] + 2'd1;
              pulse_d[i] = 1'b1;
              if (lap_d[i] == LAPS_L) begin
                pst_d[i]    = DONE;
                done_now[i] = 1'b1;
              end else begin
                pst_d[i] = NEED_CP;
              end
            end
          end
          default: ;
        endcase
      end
    end

    // P1 wins a same-cycle tie
    if (done_now[0] && (rank_q[0] == 2'd0))
      rank_d[0] = (rank_q[1] != 2'd0) ? 2'd2 : 2'd1;
    if (done_now[1] && (rank_q[1] == 2'd0))
      rank_d[1] = ((rank_q[0] != 2'd0) || done_now[0]) ? 2'd2 : 2'd1;

    // Grace runs only while exactly one player holds a place
    grace_run = (rank_q[0] != 2'd0) ^ (rank_q[1] != 2'd0);
    if (racing && grace_run) begin
      if (cnt_q == GRACE_LAST) begin
        for (int unsigned i = 0; i < 2; i++)
          if (rank_q[i] == 2'd0) rank_d[i] = 2'd2;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (clear) begin
      prev_fin_d = '0;
      prev_cp_d  = '0;
      pulse_d    = '0;
      cnt_d      = '0;
      end_d      = 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        pst_d[i]  = NEED_CP;
        lap_d[i]  = '0;
        rank_d[i] = '0;
      end
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_fin_q <= '0;
      prev_cp_q  <= '0;
      pulse_q    <= '0;
      cnt_q      <= '0;
      end_q      <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        pst_q[i]  <= NEED_CP;
        lap_q[i]  <= '0;
        rank_q[i] <= '0;
      end
    end else begin
      prev_fin_q <= prev_fin_d;
      prev_cp_q  <= prev_cp_d;
      pulse_q    <= pulse_d;
      cnt_q      <= cnt_d;
      end_q      <= end_d;
      for (int unsigned i = 0; i < 2; i++) begin
        pst_q[i]  <= pst_d[i];
        lap_q[i]  <= lap_d[i];
        rank_q[i] <= rank_d[i];
      end
    end
  end

  assign p1_lap       = lap_q[0];
  assign p2_lap       = lap_q[1];
  assign p1_lap_pulse = pulse_q[0];
  assign p2_lap_pulse = pulse_q[1];
  assign p1_rank      = rank_q[0];
  assign p2_rank      = rank_q[1];
  assign is_game_end  = end_q;

endmodule

// File: tb/tb_lap_tracker.sv
// Testbench for lap_tracker: directed race scripts plus randomized races,
// checked every cycle against a lap/place reference model via a scoreboard.
module tb_lap_tracker;

  localparam int unsigned G    = 20;
  localparam int          LAPS = 3;
  localparam logic [2:0] S_IDLE = 3'd0, S_SET = 3'd1, S_CD = 3'd3,
                         S_RACE = 3'd4, S_PAUSE = 3'd5, S_FIN = 3'd6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state = S_IDLE;
  logic [9:0] p1_x = 10'd150, p1_y = 10'd500, p2_x = 10'd150, p2_y = 10'd600;
  logic [1:0] p1_lap, p2_lap, p1_rank, p2_rank;
  logic       p1_lap_pulse, p2_lap_pulse, is_game_end;

  lap_tracker #(.LAPS(LAPS), .GRACE_CYCLES(G), .GW(30)) dut (
    .clk(clk), .rst(rst), .state(state),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .p1_lap(p1_lap), .p2_lap(p2_lap),
    .p1_lap_pulse(p1_lap_pulse), .p2_lap_pulse(p2_lap_pulse),
    .p1_rank(p1_rank), .p2_rank(p2_rank),
    .is_game_end(is_game_end)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] lap1;
    logic [1:0] lap2;
    logic       pul1;
    logic       pul2;
    logic [1:0] rank1;
    logic [1:0] rank2;
    logic       gend;
  } obs_t;

  obs_t q[$];
  obs_t mon_e, mon_a;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model: laps, "checkpoint visited" flags, places, grace time
  int   m_lap[2], m_rank[2], m_grace;
  bit   m_pulse[2], m_armed[2], m_pf[2], m_pc[2], m_end;
  logic [9:0] nx[2], ny[2];

  function automatic bit in_box(int x, int y, int x0, int x1, int y0, int y1);
    return x >= x0 && x <= x1 && y >= y0 && y <= y1;
  endfunction

  task automatic model_clear();
    m_grace = 0;
    m_end   = 0;
    for (int i = 0; i < 2; i++) begin
      m_lap[i] = 0; m_rank[i] = 0; m_pulse[i] = 0;
      m_armed[i] = 0; m_pf[i] = 0; m_pc[i] = 0;
    end
  endtask

  task automatic model_step(input logic [2:0] st, input logic r);
    bit inf[2], inc[2], fe[2], ce[2], fin_now[2];
    int old_rank[2];
    if (r || st == S_IDLE || st == S_SET) begin
      model_clear();
    end else begin
      for (int i = 0; i < 2; i++) begin
        inf[i] = in_box(int'(nx[i]), int'(ny[i]), 0, 40, 115, 120);
        inc[i] = in_box(int'(nx[i]), int'(ny[i]), 280, 319, 100, 140);
        fe[i]  = inf[i] && !m_pf[i];
        ce[i]  = inc[i] && !m_pc[i];
        old_rank[i] = m_rank[i];
        fin_now[i]  = 0;
        m_pulse[i]  = 0;
      end
      if (st == S_RACE) begin
        for (int i = 0; i < 2; i++) begin
          if (m_lap[i] < LAPS) begin
            if (!m_armed[i]) begin
              if (ce[i]) m_armed[i] = 1;
            end else if (fe[i]) begin
              m_lap[i]   = m_lap[i] + 1;
              m_pulse[i] = 1;
              m_armed[i] = 0;
              if (m_lap[i] == LAPS) fin_now[i] = 1;
            end
          end
        end
      end
      // place = 1 + players already placed (P1 counts first on a tie)
      if (fin_now[0] && old_rank[0] == 0)
        m_rank[0] = 1 + ((old_rank[1] != 0) ? 1 : 0);
      if (fin_now[1] && old_rank[1] == 0)
        m_rank[1] = 1 + ((old_rank[0] != 0 || fin_now[0]) ? 1 : 0);
      if (st == S_RACE && ((old_rank[0] != 0) != (old_rank[1] != 0))) begin
        if (m_grace == int'(G) - 1) begin
          for (int i = 0; i < 2; i++) if (old_rank[i] == 0) m_rank[i] = 2;
        end else begin
          m_grace = m_grace + 1;
        end
      end
      if (old_rank[0] != 0 && old_rank[1] != 0) m_end = 1;
      for (int i = 0; i < 2; i++) begin
        m_pf[i] = inf[i];
        m_pc[i] = inc[i];
      end
    end
  endtask

  // kind: 0 neutral, 1 checkpoint, 2 finish band
  task automatic put(input int who, input int kind);
    case (kind)
      1: begin nx[who] = 10'($urandom_range(280, 319)); ny[who] = 10'($urandom_range(100, 140)); end
      2: begin nx[who] = 10'($urandom_range(0, 40));    ny[who] = 10'($urandom_range(115, 120)); end
      default: begin nx[who] = 10'(100 + $urandom_range(0, 149)); ny[who] = 10'($urandom_range(0, 1023)); end
    endcase
  endtask

  task automatic put_xy(input int who, input int x, input int y);
    nx[who] = 10'(x);
    ny[who] = 10'(y);
  endtask

  // One clock of stimulus; expected post-edge outputs go to the scoreboard
  task automatic step(input logic [2:0] st, input logic r);
    obs_t e;
    @(negedge clk);
    state = st; rst = r;
    p1_x = nx[0]; p1_y = ny[0]; p2_x = nx[1]; p2_y = ny[1];
    model_step(st, r);
    e.lap1  = 2'(m_lap[0]);  e.lap2  = 2'(m_lap[1]);
    e.pul1  = m_pulse[0];    e.pul2  = m_pulse[1];
    e.rank1 = 2'(m_rank[0]); e.rank2 = 2'(m_rank[1]);
    e.gend  = m_end;
    q.push_back(e);
  endtask

  task automatic tick(input logic [2:0] st, input int n);
    repeat (n) step(st, 1'b0);
  endtask

  task automatic do_lap(input bit a, input bit b);
    put(0, a ? 1 : 0); put(1, b ? 1 : 0); tick(S_RACE, $urandom_range(1, 3));
    put(0, 0); put(1, 0);                 tick(S_RACE, 1);
    put(0, a ? 2 : 0); put(1, b ? 2 : 0); tick(S_RACE, $urandom_range(1, 3));
    put(0, 0); put(1, 0);                 tick(S_RACE, 1);
  endtask

  task automatic start_race();
    step(S_IDLE, 1'b0);
    step(S_SET, 1'b0);
    put(0, 0); put(1, 0);
    tick(S_CD, 2);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      mon_a.lap1  = p1_lap;       mon_a.lap2  = p2_lap;
      mon_a.pul1  = p1_lap_pulse; mon_a.pul2  = p2_lap_pulse;
      mon_a.rank1 = p1_rank;      mon_a.rank2 = p2_rank;
      mon_a.gend  = is_game_end;
      tests = tests + 1;
      if (mon_a !== mon_e) begin
        fails = fails + 1;
        $display("FAIL outputs cycle %0d: got lap=%0d/%0d pulse=%0d/%0d rank=%0d/%0d end=%0d, want lap=%0d/%0d pulse=%0d/%0d rank=%0d/%0d end=%0d",
                 cyc, mon_a.lap1, mon_a.lap2, mon_a.pul1, mon_a.pul2, mon_a.rank1, mon_a.rank2, mon_a.gend,
                 mon_e.lap1, mon_e.lap2, mon_e.pul1, mon_e.pul2, mon_e.rank1, mon_e.rank2, mon_e.gend);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ph[2], dw[2];
    int pause_left, extra;
    logic [2:0] st;
    model_clear();
    put(0, 0); put(1, 0);

    // Reset, then the start grid sitting on / moving into the finish band
    step(S_IDLE, 1'b1);
    step(S_IDLE, 1'b1);
    step(S_SET, 1'b0);
    put_xy(0, 15, 125);
    tick(S_CD, 2);
    tick(S_RACE, 2);
    put_xy(0, 15, 118);
    tick(S_RACE, 3);
    put(0, 0); tick(S_RACE, 2);
    put(0, 2); tick(S_RACE, 2);
    put(0, 0); tick(S_RACE, 1);

    // Both race; P1 finishes first, P2 crosses five cycles later
    do_lap(1, 1);
    do_lap(1, 1);
    put(0, 1); put(1, 1); tick(S_RACE, 2);
    put(0, 0); put(1, 0); tick(S_RACE, 2);
    put_xy(0, 15, 118);   tick(S_RACE, 5);
    put(1, 2);            tick(S_RACE, 3);
    put(0, 0); put(1, 0); tick(S_RACE, 4);
    tick(S_FIN, 3);
    step(S_IDLE, 1'b0);
    tick(S_FIN, 2);

    // P2 never finishes: grace expiry with a pause in the middle
    start_race();
    do_lap(1, 1);
    do_lap(1, 1);
    do_lap(1, 0);
    tick(S_RACE, 8);
    tick(S_PAUSE, 6);
    tick(S_RACE, 20);
    tick(S_FIN, 3);

    // Simultaneous final finish-line entries
    start_race();
    do_lap(1, 1);
    do_lap(1, 1);
    do_lap(1, 1);
    tick(S_RACE, 3);

    // Movement during pause, resume already inside the finish band
    start_race();
    put(0, 1); tick(S_RACE, 1);
    put(0, 0); tick(S_RACE, 1);
    put(0, 1); tick(S_PAUSE, 2);
    put(0, 0); tick(S_PAUSE, 1);
    put(0, 2); tick(S_PAUSE, 2);
    tick(S_RACE, 3);
    put(0, 0); tick(S_RACE, 1);
    put(0, 2); tick(S_RACE, 2);

    // Reset asserted mid-lap, then finish band right after reset
    put(0, 1); tick(S_RACE, 2);
    put(0, 0); tick(S_RACE, 1);
    step(S_RACE, 1'b1);
    put(0, 2); tick(S_RACE, 3);

    // Randomized races with pauses, reversals and occasional resets
    for (int r = 0; r < 15; r++) begin
      start_race();
      ph = '{0, 0};
      dw = '{1, 1};
      pause_left = 0;
      extra = -1;
      for (int c = 0; c < 400; c++) begin
        for (int i = 0; i < 2; i++) begin
          dw[i] = dw[i] - 1;
          if (dw[i] <= 0) begin
            if ($urandom_range(0, 9) == 0) ph[i] = (ph[i] + 3) % 4;
            else                           ph[i] = (ph[i] + 1) % 4;
            dw[i] = $urandom_range(1, 4);
          end
          put(i, (ph[i] == 1) ? 1 : (ph[i] == 3) ? 2 : 0);
        end
        if (pause_left > 0) begin
          st = S_PAUSE;
          pause_left = pause_left - 1;
        end else begin
          st = S_RACE;
          if ($urandom_range(0, 39) == 0) pause_left = $urandom_range(1, 6);
        end
        step(st, ($urandom_range(0, 299) == 0));
        if (m_end && extra < 0) extra = 3;
        if (extra > 0) extra = extra - 1;
        if (extra == 0) break;
      end
      tick(S_FIN, 2);
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    tests = tests + 1;
    if (q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lap_tracker.md
Name: lap_tracker

Overview:
- Sits directly downstream of the two PhysicsEngine instances and upstream of StateEncoder and the HUD flag renderer.
- Watches each car's world position and counts valid laps; a lap needs a checkpoint visit followed by a finish-line entry.
- Assigns finishing order and drives is_game_end, which StateEncoder currently has tied to 0.
- Its p1_rank and p2_rank outputs replace the flag-order values shown on the HUD.

Parameters:
- LAPS, 3: laps to finish; legal range 1..3.
- FIN_X0, 0 / FIN_X1, 40 / FIN_Y0, 115 / FIN_Y1, 120: finish-line rectangle in world coordinates, bounds inclusive.
- CP_X0, 280 / CP_X1, 319 / CP_Y0, 100 / CP_Y1, 140: checkpoint rectangle, bounds inclusive.
- GRACE_CYCLES, 1000000000: clk cycles after the first finisher before the race is forced to end (10 s at 100 MHz).
- GW, 30: width of the grace counter.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- state  in  3  game FSM state (IDLE=0, SETTING=1, COUNTDOWN=3, RACING=4, PAUSE=5, FINISH=6)
- p1_x, p1_y  in  10 each  P1 world position
- p2_x, p2_y  in  10 each  P2 world position
- p1_lap, p2_lap  out  2 each  completed laps, saturating at LAPS
- p1_lap_pulse, p2_lap_pulse  out  1 each  one-cycle pulse per counted lap (for audio)
- p1_rank, p2_rank  out  2 each  0 = racing, 1 = first, 2 = second
- is_game_end  out  1  level; to StateEncoder

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0; both player FSMs in NEED_CP; grace counter 0; region-history registers 0.
- Clear condition: when state is IDLE or SETTING, the block applies the same clear as reset on every cycle. A new race therefore always starts clean.
- Region flags (combinational): in_fin and in_cp per player, from inclusive rectangle compares on unsigned 10-bit coordinates.
- Entry detection:
  - prev_fin and prev_cp are registered every cycle in every state, so no false edge appears on resume.
  - fin_entry = in_fin & ~prev_fin; cp_entry is formed the same way.
- Advance enable: only when state == RACING. COUNTDOWN, PAUSE and FINISH hold all counters and FSMs.
- Per-player FSM:
  - NEED_CP: cp_entry moves to NEED_FIN. A finish-line entry here is ignored, so the start grid sitting near the line cannot count a lap and reversing across the line does nothing.
  - NEED_FIN: fin_entry increments lap and pulses lap_pulse for exactly one cycle.
    - If the new lap == LAPS, go to DONE and assign rank.
    - Otherwise return to NEED_CP.
  - DONE: terminal until reset or clear. Lap and rank hold.
- Simultaneous in_cp and in_fin (overlapping regions): the checkpoint transition is evaluated first, and at most one transition happens per cycle.
- Rank assignment:
  - The first player to enter DONE gets rank 1; the other later gets rank 2.
  - If both enter DONE in the same cycle, P1 gets rank 1 and P2 gets rank 2.
  - Rank is registered and visible the cycle after the DONE transition.
- Grace counter:
  - Starts the cycle after the first rank is assigned.
  - Increments only while state == RACING, so it freezes in PAUSE.
  - When it reaches GRACE_CYCLES-1 and the other player is not done, that player's rank is forced to 2.
- is_game_end:
  - Goes high the cycle after both ranks are non-zero.
  - Stays high until clear or reset; it is not dependent on state.
- Reset or clear mid-race aborts immediately; no pulse is emitted on that cycle.
- Lap arithmetic is 2-bit and cannot exceed LAPS.

Test Plan:
- Reset, then state=RACING with P1 at (15,125) moved into the finish band (15,118) -> p1_lap stays 0 and no pulse (the start line does not count).
- P1 path: checkpoint (300,120), then finish (15,118), repeated three times -> p1_lap goes 1, 2, 3; three single-cycle p1_lap_pulse; p1_rank=1 one cycle after the third entry; is_game_end=0.
- Continue with GRACE_CYCLES=20: P2 finishes 5 cycles later -> p2_rank=2 and is_game_end=1 the next cycle. Separate run where P2 never finishes -> p2_rank forced to 2 at grace expiry and is_game_end=1 one cycle later.
- Both players make their final finish-line entry on the same cycle -> p1_rank=1, p2_rank=2, is_game_end=1 one cycle later.
- State=PAUSE while P1 moves checkpoint then finish, then resume RACING with P1 already inside the finish band -> lap unchanged and no pulse; grace counter value is unchanged across the pause.
- is_game_end=1, then state=IDLE for one cycle -> all outputs 0. Separate run asserting rst mid-lap -> all outputs 0 the following cycle.
